// File: rtl/alu_col_pkg.sv
// Shared definitions for the ALU result collector.
// Source unit encodings, the layout of a tagged FIFO entry, and a small
// helper that spots more than one unit reporting in the same cycle.
package alu_col_pkg;

  typedef enum logic [1:0] {
    SRC_ARITH = 2'd0,
    SRC_LOGIC = 2'd1,
    SRC_CMP   = 2'd2,
    SRC_SHIFT = 2'd3
  } src_e;

  // An entry is {zero, carry, src[1:0], data}, so the tag adds 4 bits above the data.
  localparam int unsigned ENTRY_TAG_W = 4;

  // True when two or more bits of the flag vector are set.
  function automatic logic more_than_one(input logic [3:0] flags);
    return (flags & (flags - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/alu_res_fifo.sv
// Parameterised synchronous FIFO for tagged ALU results.
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   push, wr_data   : write request and entry to store
//   pop             : remove the head entry
//   rd_data         : head entry, combinational read at the read pointer
//   full, empty     : occupancy status
//   count           : number of entries held (0..DEPTH)
// Storage is not reset; only pointers and count are.
module alu_res_fifo #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned      PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  // A push into a full FIFO is only legal when the head leaves on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_collector.sv
// ALU result collector: picks the one active unit result per cycle
// (priority ARITH > LOGIC > CMP > SHIFT), tags it with source, carry and
// zero status, and queues it for the consumer over a valid/ready handshake.
// Ports:
//   CLK_COL, RST_COL         : clock, synchronous active-high reset
//   *_OUT_COL / *_Flag_COL   : unit results and their valid flags
//   Carry_out_COL            : arithmetic carry, used only when arith wins
//   RES_READY                : consumer accepts the head entry
//   CLR_STICKY               : clears the sticky status bits
//   RES_VALID/DATA/SRC/CARRY/ZERO : head entry, all 0 when empty
//   RES_COUNT                : entries held
//   OVF_STICKY               : a result was dropped on a full FIFO
//   ERR_STICKY               : several units reported in one cycle
module alu_result_collector
  import alu_col_pkg::*;
#(
  parameter int unsigned DATA_width = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_width  = 3
) (
  input  logic                  CLK_COL,
  input  logic                  RST_COL,
  input  logic [DATA_width-1:0] ARITH_OUT_COL,
  input  logic                  Carry_out_COL,
  input  logic                  ARITH_Flag_COL,
  input  logic [DATA_width-1:0] LOGIC_OUT_COL,
  input  logic                  LOGIC_Flag_COL,
  input  logic [DATA_width-1:0] CMP_OUT_COL,
  input  logic                  CMP_Flag_COL,
  input  logic [DATA_width-1:0] SHIFT_OUT_COL,
  input  logic                  SHIFT_Flag_COL,
  input  logic                  RES_READY,
  input  logic                  CLR_STICKY,
  output logic                  RES_VALID,
  output logic [DATA_width-1:0] RES_DATA,
  output logic [1:0]            RES_SRC,
  output logic                  RES_CARRY,
  output logic                  RES_ZERO,
  output logic [CNT_width-1:0]  RES_COUNT,
  output logic                  OVF_STICKY,
  output logic                  ERR_STICKY
);

  localparam int unsigned ENTRY_W = DATA_width + ENTRY_TAG_W;

  logic [3:0]            flags;
  logic                  push_req;
  logic                  multi_src;
  src_e                  sel_src;
  logic [DATA_width-1:0] sel_data;
  logic                  sel_carry;
  logic                  sel_zero;
  logic [ENTRY_W-1:0]    wr_entry;
  logic [ENTRY_W-1:0]    rd_entry;
  logic [ENTRY_W-1:0]    head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic                  push;
  logic                  drop;

  assign flags     = {ARITH_Flag_COL, LOGIC_Flag_COL, CMP_Flag_COL, SHIFT_Flag_COL};
  assign push_req  = |flags;
  assign multi_src = more_than_one(flags);

  always_comb begin
    sel_src   = SRC_SHIFT;
    sel_data  = SHIFT_OUT_COL;
    sel_carry = 1'b0;
    if (ARITH_Flag_COL) begin
      sel_src   = SRC_ARITH;
      sel_data  = ARITH_OUT_COL;
      sel_carry = Carry_out_COL;
    end else if (LOGIC_Flag_COL) begin
      sel_src  = SRC_LOGIC;
      sel_data = LOGIC_OUT_COL;
    end else if (CMP_Flag_COL) begin
      sel_src  = SRC_CMP;
      sel_data = CMP_OUT_COL;
    end
  end

  assign sel_zero = (sel_data == '0);
  assign wr_entry = {sel_zero, sel_carry, sel_src, sel_data};

  assign pop  = RES_VALID && RES_READY;
  assign drop = push_req && fifo_full && !pop;
  assign push = push_req && !drop;

  alu_res_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_width)
  ) u_fifo (
    .clk     (CLK_COL),
    .rst     (RST_COL),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (RES_COUNT)
  );

  assign head      = fifo_empty ? '0 : rd_entry;
  assign RES_VALID = !fifo_empty;
  assign RES_DATA  = head[DATA_width-1:0];
  assign RES_SRC   = head[DATA_width+1:DATA_width];
  assign RES_CARRY = head[DATA_width+2];
  assign RES_ZERO  = head[DATA_width+3];

  // Set conditions win over a clear in the same cycle.
  always_ff @(posedge CLK_COL) begin
    if (RST_COL) begin
      OVF_STICKY <= 1'b0;
      ERR_STICKY <= 1'b0;
    end else begin
      if (drop)            OVF_STICKY <= 1'b1;
      else if (CLR_STICKY) OVF_STICKY <= 1'b0;
      if (multi_src)       ERR_STICKY <= 1'b1;
      else if (CLR_STICKY) ERR_STICKY <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_result_collector.sv
// Directed, table-driven bench for alu_result_collector.
module tb_alu_result_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] arith_out, logic_out, cmp_out, shift_out;
  logic        carry_in, arith_f, logic_f, cmp_f, shift_f;
  logic        ready, clr;
  logic        res_valid, res_carry, res_zero, ovf, err;
  logic [15:0] res_data;
  logic [1:0]  res_src;
  logic [2:0]  res_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_result_collector #(
    .DATA_width (16),
    .FIFO_DEPTH (4),
    .CNT_width  (3)
  ) dut (
    .CLK_COL        (clk),
    .RST_COL        (rst),
    .ARITH_OUT_COL  (arith_out),
    .Carry_out_COL  (carry_in),
    .ARITH_Flag_COL (arith_f),
    .LOGIC_OUT_COL  (logic_out),
    .LOGIC_Flag_COL (logic_f),
    .CMP_OUT_COL    (cmp_out),
    .CMP_Flag_COL   (cmp_f),
    .SHIFT_OUT_COL  (shift_out),
    .SHIFT_Flag_COL (shift_f),
    .RES_READY      (ready),
    .CLR_STICKY     (clr),
    .RES_VALID      (res_valid),
    .RES_DATA       (res_data),
    .RES_SRC        (res_src),
    .RES_CARRY      (res_carry),
    .RES_ZERO       (res_zero),
    .RES_COUNT      (res_count),
    .OVF_STICKY     (ovf),
    .ERR_STICKY     (err)
  );

  // One clock cycle of stimulus and the outputs expected just after its edge.
  // mask = {arith, logic, cmp, shift}.
  typedef struct {
    logic        rst;
    logic [3:0]  mask;
    logic [15:0] d;
    logic        cy;
    logic        rdy;
    logic        clr;
    logic        e_valid;
    logic [15:0] e_data;
    logic [1:0]  e_src;
    logic        e_carry;
    logic        e_zero;
    logic [2:0]  e_cnt;
    logic        e_ovf;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [3:0] m, logic [15:0] d, logic cy, logic rdy,
                              logic c, logic ev, logic [15:0] ed, logic [1:0] es,
                              logic ec, logic ez, logic [2:0] en, logic eo, logic ee);
    vec_t v;
    v.rst = r; v.mask = m; v.d = d; v.cy = cy; v.rdy = rdy; v.clr = c;
    v.e_valid = ev; v.e_data = ed; v.e_src = es; v.e_carry = ec; v.e_zero = ez;
    v.e_cnt = en; v.e_ovf = eo; v.e_err = ee;
    return v;
  endfunction

  // Highest-priority flagged unit gets d; other flagged units get ~d; idle units get junk.
  task automatic drive(input logic r, input logic [3:0] m, input logic [15:0] d,
                       input logic cy, input logic rdy, input logic c);
    logic first;
    logic [15:0] vals [4];
    first = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) begin
        vals[3-i] = first ? d : ~d;
        first = 1'b0;
      end else begin
        vals[3-i] = 16'hDEAD;
      end
    end
    rst = r; ready = rdy; clr = c; carry_in = cy;
    {arith_f, logic_f, cmp_f, shift_f} = m;
    arith_out = vals[0]; logic_out = vals[1]; cmp_out = vals[2]; shift_out = vals[3];
  endtask

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input vec_t v);
    chk("valid", idx, 16'(res_valid), 16'(v.e_valid));
    chk("data",  idx, res_data,        v.e_data);
    chk("src",   idx, 16'(res_src),    16'(v.e_src));
    chk("carry", idx, 16'(res_carry),  16'(v.e_carry));
    chk("zero",  idx, 16'(res_zero),   16'(v.e_zero));
    chk("count", idx, 16'(res_count),  16'(v.e_cnt));
    chk("ovf",   idx, 16'(ovf),        16'(v.e_ovf));
    chk("err",   idx, 16'(err),        16'(v.e_err));
  endtask

  localparam logic [3:0] N = 4'b0000, A = 4'b1000, L = 4'b0100, C = 4'b0010, S = 4'b0001;

  initial begin
    drive(1'b1, N, 16'h0, 1'b0, 1'b0, 1'b0);

    //           rst mask  d        cy rdy clr | valid data     src c z cnt ovf err
    // reset state
    tbl.push_back(mk(1, N, 16'h0000, 0, 0, 0,   0, 16'h0000, 0, 0, 0, 0, 0, 0));
    // single arith result, popped next cycle
    tbl.push_back(mk(0, A, 16'h1234, 1, 1, 0,   1, 16'h1234, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, N, 16'h0000, 0, 1, 0,   0, 16'h0000, 0, 0, 0, 0, 0, 0));
    // ordering, carry gated off for non-arith, zero tag
    tbl.push_back(mk(0, L, 16'h0000, 1, 0, 0,   1, 16'h0000, 1, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, C, 16'h0001, 1, 0, 0,   1, 16'h0000, 1, 0, 1, 2, 0, 0));
    tbl.push_back(mk(0, S, 16'h8000, 1, 0, 0,   1, 16'h0000, 1, 0, 1, 3, 0, 0));
    tbl.push_back(mk(0, N, 16'h0000, 0, 1, 0,   1, 16'h0001, 2, 0, 0, 2, 0, 0));
    tbl.push_back(mk(0, N, 16'h0000, 0, 1, 0,   1, 16'h8000, 3, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, N, 16'h0000, 0, 1, 0,   0, 16'h0000, 0, 0, 0, 0, 0, 0));
    // overflow: fifth push dropped
    tbl.push_back(mk(0, A, 16'h0011, 0, 0, 0,   1, 16'h0011, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, L, 16'h0022, 0, 0, 0,   1, 16'h0011, 0, 0, 0, 2, 0, 0));
    tbl.push_back(mk(0, C, 16'h0033, 0, 0, 0,   1, 16'h0011, 0, 0, 0, 3, 0, 0));
    tbl.push_back(mk(0, S, 16'h0044, 0, 0, 0,   1, 16'h0011, 0, 0, 0, 4, 0, 0));
    tbl.push_back(mk(0, A, 16'h0055, 1, 0, 0,   1, 16'h0011, 0, 0, 0, 4, 1, 0));
    tbl.push_back(mk(0, N, 16'h0000, 0, 1, 0,   1, 16'h0022, 1, 0, 0, 3, 1, 0));
    tbl.push_back(mk(0, N, 16'h0000, 0, 1, 0,   1, 16'h0033, 2, 0, 0, 2, 1, 0));
    tbl.push_back(mk(0, N, 16'h0000, 0, 1, 0,   1, 16'h0044, 3, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, N, 16'h0000, 0, 1, 0,   0, 16'h0000, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, N, 16'h0000, 0, 0, 1,   0, 16'h0000, 0, 0, 0, 0, 0, 0));
    // full FIFO, push with simultaneous pop is accepted
    tbl.push_back(mk(0, A, 16'h0101, 0, 0, 0,   1, 16'h0101, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, A, 16'h0202, 0, 0, 0,   1, 16'h0101, 0, 0, 0, 2, 0, 0));
    tbl.push_back(mk(0, A, 16'h0303, 0, 0, 0,   1, 16'h0101, 0, 0, 0, 3, 0, 0));
    tbl.push_back(mk(0, A, 16'h0404, 0, 0, 0,   1, 16'h0101, 0, 0, 0, 4, 0, 0));
    tbl.push_back(mk(0, A, 16'hBEEF, 0, 1, 0,   1, 16'h0202, 0, 0, 0, 4, 0, 0));
    tbl.push_back(mk(0, N, 16'h0000, 0, 1, 0,   1, 16'h0303, 0, 0, 0, 3, 0, 0));
    tbl.push_back(mk(0, N, 16'h0000, 0, 1, 0,   1, 16'h0404, 0, 0, 0, 2, 0, 0));
    tbl.push_back(mk(0, N, 16'h0000, 0, 1, 0,   1, 16'hBEEF, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, N, 16'h0000, 0, 1, 0,   0, 16'h0000, 0, 0, 0, 0, 0, 0));
    // multi-flag: arith wins, error sticky; set beats clear
    tbl.push_back(mk(0, A|S, 16'h0007, 0, 0, 0, 1, 16'h0007, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, N, 16'h0000, 0, 0, 0,   1, 16'h0007, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, L|C, 16'h0000, 0, 0, 1, 1, 16'h0007, 0, 0, 0, 2, 0, 1));
    tbl.push_back(mk(0, C, 16'h00AA, 0, 0, 0,   1, 16'h0007, 0, 0, 0, 3, 0, 1));
    // reset mid-operation discards entries and ignores a concurrent flag
    tbl.push_back(mk(1, A, 16'h1111, 1, 0, 0,   0, 16'h0000, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, S, 16'h0F0F, 0, 0, 0,   1, 16'h0F0F, 3, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, N, 16'h0000, 0, 1, 0,   0, 16'h0000, 0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].mask, tbl[i].d, tbl[i].cy, tbl[i].rdy, tbl[i].clr);
      @(posedge clk);
      #1;
      check_all(i, tbl[i]);
    end

    // Streaming: push every cycle with the consumer always ready keeps one entry in flight.
    for (int k = 0; k < 5; k++) begin
      logic [15:0] val;
      val = 16'h0A00 + 16'(k);
      drive(1'b0, A, val, k[0], 1'b1, 1'b0);
      @(posedge clk);
      #1;
      chk("stream_cnt",   100 + k, 16'(res_count), 16'd1);
      chk("stream_data",  100 + k, res_data, val);
      chk("stream_carry", 100 + k, 16'(res_carry), 16'(k[0]));
    end
    drive(1'b0, N, 16'h0, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("stream_drain", 105, 16'(res_valid), 16'd0);

    // Stable head while stalled: outputs hold across idle cycles.
    drive(1'b0, L, 16'h5A5A, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, N, 16'h0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("stall_data", 110 + k, res_data, 16'h5A5A);
      chk("stall_src",  110 + k, 16'(res_src), 16'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
